// File: rtl/keypad_entry_ctrl.sv
// ============================================================================
// keypad_entry_ctrl - 4x3 keypad scan/debounce, BCD entry, BCD-to-binary conversion, valid/ready output. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module keypad_entry_ctrl #(
  parameter int NUM_DIGITS = 9,
  parameter int BIN_W      = 64,
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [2:0]                            key_col,
  output logic [3:0]                            key_row,
  input  logic                                  out_ready,
  output logic                                  key_valid,
  output logic [3:0]                            key_code,
  output logic [4*NUM_DIGITS-1:0]               bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]       digit_cnt,
  output logic [BIN_W-1:0]                      bin,
  output logic                                  out_valid,
  output logic                                  busy
);

  localparam int CW  = $clog2(NUM_DIGITS + 1);
  localparam int BW  = 4 * NUM_DIGITS;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  logic [SCW-1:0] scan_cnt;
  logic [1:0]     row_idx;
  logic           found;
  logic [3:0]     cap_code;
  logic           hit_prev;
  logic [3:0]     code_prev;
  logic [DBW-1:0] stab_cnt;
  logic           armed;

  logic           dwell_end, frame_end, col_hit, frame_hit, same_key, key_evt, rearm;
  logic [1:0]     col_sel;
  logic [3:0]     this_code, frame_code;
  logic [DBW-1:0] next_cnt;

  state_t         state;
  logic [BIN_W-1:0] acc, acc_next;
  logic [CW-1:0]  conv_idx;
  logic [3:0]     cur_digit;

  always_comb begin
    dwell_end = (scan_cnt == SCW'(SCAN_DIV - 1));
    frame_end = dwell_end && (row_idx == 2'd3);
    col_hit   = |key_col;
    if (key_col[2])      col_sel = 2'd0;
    else if (key_col[1]) col_sel = 2'd1;
    else                 col_sel = 2'd2;
    case (row_idx)
      2'd0:    this_code = 4'd1 + {2'b00, col_sel};
      2'd1:    this_code = 4'd4 + {2'b00, col_sel};
      2'd2:    this_code = 4'd7 + {2'b00, col_sel};
      default: begin
        case (col_sel)
          2'd0:    this_code = 4'd10;
          2'd1:    this_code = 4'd0;
          default: this_code = 4'd11;
        endcase
      end
    endcase
    // An earlier row in the same frame always takes priority over this one
    frame_hit  = found | col_hit;
    frame_code = found ? cap_code : this_code;
    same_key   = (frame_hit == hit_prev) && (!frame_hit || (frame_code == code_prev));
    if (!same_key)                      next_cnt = DBW'(1);
    else if (stab_cnt == DBW'(DEBOUNCE)) next_cnt = stab_cnt;
    else                                next_cnt = stab_cnt + DBW'(1);
    key_evt = frame_end && armed && frame_hit && (next_cnt == DBW'(DEBOUNCE));
    rearm   = frame_end && !armed && !frame_hit && (next_cnt == DBW'(DEBOUNCE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      row_idx   <= 2'd0;
      key_row   <= 4'b1000;
      found     <= 1'b0;
      cap_code  <= 4'd0;
      hit_prev  <= 1'b0;
      code_prev <= 4'd0;
      stab_cnt  <= '0;
      armed     <= 1'b1;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= key_evt;
      if (key_evt) key_code <= frame_code;
      if (dwell_end) begin
        scan_cnt <= '0;
        row_idx  <= row_idx + 2'd1;
        key_row  <= {key_row[0], key_row[3:1]};
        if (frame_end) begin
          found     <= 1'b0;
          hit_prev  <= frame_hit;
          code_prev <= frame_code;
          stab_cnt  <= next_cnt;
          if (key_evt) armed <= 1'b0;
          if (rearm)   armed <= 1'b1;
        end else if (!found && col_hit) begin
          found    <= 1'b1;
          cap_code <= this_code;
        end
      end else begin
        scan_cnt <= scan_cnt + SCW'(1);
      end
    end
  end

  // Most significant digit first, leading zeros included
  always_comb begin
    cur_digit = 4'(bcd >> (4 * (NUM_DIGITS - 1 - int'(conv_idx))));
    acc_next  = (acc << 3) + (acc << 1) + BIN_W'(cur_digit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bcd       <= '0;
      digit_cnt <= '0;
      acc       <= '0;
      conv_idx  <= '0;
      bin       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      bcd       <= '0;
      digit_cnt <= '0;
      acc       <= '0;
      conv_idx  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Digits and backspace act on the edge the key is reported; Enter acts one cycle later
          if (key_evt && (frame_code <= 4'd9)) begin
            if (digit_cnt < CW'(NUM_DIGITS)) begin
              bcd       <= (bcd << 4) | BW'(frame_code);
              digit_cnt <= digit_cnt + CW'(1);
            end
          end else if (key_evt && (frame_code == 4'd10)) begin
            if (digit_cnt != '0) begin
              bcd       <= bcd >> 4;
              digit_cnt <= digit_cnt - CW'(1);
            end
          end else if (key_valid && (key_code == 4'd11) && (digit_cnt != '0)) begin
            acc      <= '0;
            conv_idx <= '0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          acc <= acc_next;
          if (conv_idx == CW'(NUM_DIGITS - 1)) begin
            bin       <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            conv_idx <= conv_idx + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            bcd       <= '0;
            digit_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
// ============================================================================
// tb_keypad_entry_ctrl - scoreboard bench for keypad_entry_ctrl. Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_keypad_entry_ctrl;

  localparam int ND    = 9;
  localparam int BW    = 64;
  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 4 * SD;
  localparam int CW    = $clog2(ND + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [2:0]    key_col;
  logic [3:0]    key_row;
  logic          out_ready;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [4*ND-1:0] bcd;
  logic [CW-1:0] digit_cnt;
  logic [BW-1:0] bin;
  logic          out_valid;
  logic          busy;

  keypad_entry_ctrl #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .flush(flush), .key_col(key_col), .key_row(key_row),
    .out_ready(out_ready), .key_valid(key_valid), .key_code(key_code), .bcd(bcd),
    .digit_cnt(digit_cnt), .bin(bin), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Physical keypad: bit r*3+c is the key at row r, column c (c=0 is left)
  logic [11:0] pressed;
  always_comb begin
    key_col = 3'b000;
    for (int r = 0; r < 4; r++)
      if (key_row[3-r])
        for (int c = 0; c < 3; c++)
          if (pressed[r*3+c]) key_col = key_col | (3'b100 >> c);
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          kv_count = 0;
  longint      cyc      = 0;
  longint      busy_rise = 0;
  logic        busy_d = 1'b0;
  logic        ov_d   = 1'b0;
  logic [3:0]  exp_keys[$];
  logic [BW-1:0] exp_bins[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int key_idx(input int code);
    if (code >= 1 && code <= 9) return code - 1;
    else if (code == 0)         return 10;
    else if (code == 10)        return 9;
    else                        return 11;
  endfunction

  // Monitor: pops expected keys and results as the DUT presents them
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (key_valid) begin
        kv_count++;
        if (exp_keys.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_key: got code %0d, expected no event", key_code);
        end else begin
          check("key_code", 64'(key_code), 64'(exp_keys.pop_front()));
        end
      end
      if (busy && !busy_d) busy_rise = cyc;
      if (out_valid && !ov_d) check("conv_latency", 64'(cyc - busy_rise), 64'(ND));
      if (out_valid && out_ready) begin
        if (exp_bins.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got bin %0d, expected no handshake", bin);
        end else begin
          check("bin", bin, exp_bins.pop_front());
        end
      end
    end
    busy_d = busy;
    ov_d   = out_valid;
  end

  task automatic press_mask(input logic [11:0] mask, input int hold_frames,
                            input bit expect_evt, input int code);
    @(negedge clk);
    if (expect_evt) exp_keys.push_back(4'(code));
    pressed = mask;
    repeat (hold_frames * FRAME) @(negedge clk);
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk);
  endtask

  task automatic key(input int code);
    press_mask(12'(1) << key_idx(code), 4, 1'b1, code);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kv0;
    int waited;
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1; pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_key_row",   64'(key_row), 64'(4'b1000));
    check("rst_key_valid", 64'(key_valid), 64'd0);
    check("rst_bcd",       64'(bcd), 64'd0);
    check("rst_outputs",   64'({bin != '0, out_valid, busy, digit_cnt != '0, key_code != '0}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    repeat (SD - 1) @(negedge clk);
    check("scan_row1", 64'(key_row), 64'(4'b0100));

    // Basic entry and conversion
    key(1);
    key(9);
    check("entry_bcd", 64'(bcd), 64'h19);
    check("entry_cnt", 64'(digit_cnt), 64'd2);
    exp_bins.push_back(64'd19);
    key(11);
    check("post_hs_bcd", 64'(bcd), 64'd0);
    check("post_hs_cnt", 64'(digit_cnt), 64'd0);
    check("post_hs_busy", 64'(busy), 64'd0);

    // Backspace
    key(1); key(2); key(3); key(10);
    check("bksp_bcd", 64'(bcd), 64'h12);
    check("bksp_cnt", 64'(digit_cnt), 64'd2);
    key(10); key(10);
    check("bksp_empty_cnt", 64'(digit_cnt), 64'd0);
    key(10);
    check("bksp_zero_bcd", 64'(bcd), 64'd0);
    check("bksp_zero_cnt", 64'(digit_cnt), 64'd0);

    // Full register: tenth digit ignored
    for (int i = 0; i < 10; i++) key(9);
    check("full_cnt", 64'(digit_cnt), 64'd9);
    check("full_bcd", 64'(bcd), 64'h999999999);
    exp_bins.push_back(64'd999999999);
    key(11);
    check("full_post_cnt", 64'(digit_cnt), 64'd0);

    // Debounce
    kv0 = kv_count;
    press_mask(12'(1) << key_idx(4), DB - 1, 1'b0, 4);
    check("short_press_events", 64'(kv_count - kv0), 64'd0);
    kv0 = kv_count;
    press_mask(12'(1) << key_idx(6), 5, 1'b1, 6);
    check("long_press_events", 64'(kv_count - kv0), 64'd1);
    press_mask((12'(1) << key_idx(1)) | (12'(1) << key_idx(9)), 4, 1'b1, 1);
    check("multi_bcd", 64'(bcd), 64'h61);
    @(negedge clk);
    pulse_flush();
    check("flush_idle_cnt", 64'(digit_cnt), 64'd0);
    check("flush_idle_bcd", 64'(bcd), 64'd0);

    // Abort in DONE with flush
    out_ready = 1'b0;
    key(7);
    key(11);
    check("done_valid", 64'(out_valid), 64'd1);
    check("done_bin", bin, 64'd7);
    repeat (100) @(negedge clk);
    check("done_hold_valid", 64'(out_valid), 64'd1);
    check("done_hold_bin", bin, 64'd7);
    pulse_flush();
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_cnt", 64'(digit_cnt), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_bin_kept", bin, 64'd7);
    out_ready = 1'b1;

    // Reset in the middle of CONV
    key(5);
    check("pre_rst_bcd", 64'(bcd), 64'h5);
    @(negedge clk);
    exp_keys.push_back(4'd11);
    pressed = 12'(1) << key_idx(11);
    waited = 0;
    while (!busy && waited < 10 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    check("busy_timeout", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_conv_busy", 64'(busy), 64'd0);
    check("rst_conv_valid", 64'(out_valid), 64'd0);
    check("rst_conv_bcd", 64'(bcd), 64'd0);
    check("rst_conv_row", 64'(key_row), 64'(4'b1000));
    pressed = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_rel_row", 64'(key_row), 64'(4'b1000));
    repeat (SD) @(negedge clk);
    check("rst_rel_row1", 64'(key_row), 64'(4'b0100));
    repeat (4 * FRAME) @(negedge clk);

    // Recovery after reset
    key(4);
    key(2);
    exp_bins.push_back(64'd42);
    key(11);
    check("recover_cnt", 64'(digit_cnt), 64'd0);

    repeat (10) @(negedge clk);
    check("keys_drained", 64'(exp_keys.size()), 64'd0);
    check("bins_drained", 64'(exp_bins.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
